// File: rtl/data_memory.sv
// 256 x 8 data memory with a fixed multi-cycle access latency.
// BUSYWAIT stalls the CPU from request acceptance until the access completes.
module data_memory #(
    parameter int unsigned LATENCY = 5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       read_i,
    input  logic       write_i,
    input  logic [7:0] address_i,
    input  logic [7:0] writedata_i,
    output logic [7:0] readdata_o,
    output logic       busywait_o
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       op_write_q, op_write_d;
    logic [7:0] readdata_q;
    logic [7:0] mem_q [256];

    logic req_valid;
    logic access;

    // Both READ and WRITE high is not a request.
    assign req_valid = read_i ^ write_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_write_d = op_write_q;
        access     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d     = address_i;
                    wdata_d    = writedata_i;
                    op_write_d = write_i;
                    cnt_d      = CntLoad;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busywait_o = (state_q == StBusy) || ((state_q == StIdle) && req_valid);
    assign readdata_o = readdata_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            op_write_q <= 1'b0;
            readdata_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_write_q <= op_write_d;
            if (access && !op_write_q) begin
                readdata_q <= mem_q[addr_q];
            end
        end
    end

    // Array is never cleared; reset only suppresses a completing write.
    always_ff @(posedge clk_i) begin
        if (!reset_i && access && op_write_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes expected completions into a
// scoreboard queue, a negedge monitor pops and compares at each DONE cycle.
module tb_data_memory;

    localparam int unsigned LAT = 5;

    typedef struct {
        logic [7:0] rd;
        int         hi;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       read;
    logic       write;
    logic [7:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       busywait;

    int   errors;
    int   checks;
    bit   mon_en;
    int   hi_cnt;
    bit   prev_bw;
    exp_t sb[$];

    logic [7:0] model [256];
    logic [7:0] rd_model;

    data_memory #(
        .LATENCY(LAT)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .read_i     (read),
        .write_i    (write),
        .address_i  (address),
        .writedata_i(writedata),
        .readdata_o (readdata),
        .busywait_o (busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: a high-to-low BUSYWAIT transition marks the DONE cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            hi_cnt  = 0;
            prev_bw = 1'b0;
        end else if (busywait) begin
            hi_cnt++;
            prev_bw = 1'b1;
        end else if (prev_bw) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", 1, 0);
            end else begin
                e = sb.pop_front();
                check("readdata", int'(readdata), int'(e.rd));
                check("busy_cycles", hi_cnt, e.hi);
            end
            hi_cnt  = 0;
            prev_bw = 1'b0;
        end
    end

    task automatic access(input bit w, input logic [7:0] a, input logic [7:0] d,
                          input bit alt, input logic [7:0] alt_a);
        exp_t e;
        int   n;
        bit   done;
        if (w) begin
            model[a] = d;
        end else begin
            rd_model = model[a];
        end
        e.rd = rd_model;
        e.hi = LAT + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        write     = w;
        read      = !w;
        address   = a;
        writedata = d;
        n         = 0;
        done      = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (!busywait) done = 1'b1;
            else if (alt && n == 3) address = alt_a;
        end
        if (!done) check("busywait_timeout", 1, 0);
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    // Write request abandoned by a reset at edge k+off (k = acceptance edge).
    task automatic reset_during(input logic [7:0] a, input logic [7:0] d, input int off);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        write     = 1'b1;
        read      = 1'b0;
        address   = a;
        writedata = d;
        repeat (off) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        write    = 1'b0;
        rd_model = 8'h00;
        @(negedge clk);
        check("reset_busywait", int'(busywait), 0);
        check("reset_readdata", int'(readdata), 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        mon_en    = 1'b0;
        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = 8'h00;
        writedata = 8'h00;
        rd_model  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("init_readdata", int'(readdata), 0);
        check("init_busywait", int'(busywait), 0);
        mon_en = 1'b1;

        access(1'b1, 8'h2A, 8'h5C, 1'b0, 8'h00);
        access(1'b0, 8'h2A, 8'h00, 1'b0, 8'h00);

        access(1'b1, 8'h00, 8'h11, 1'b0, 8'h00);
        access(1'b1, 8'hFF, 8'h22, 1'b0, 8'h00);
        access(1'b0, 8'hFF, 8'h00, 1'b0, 8'h00);
        access(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

        // Address moves mid-access; the latched address must win.
        access(1'b1, 8'h10, 8'h33, 1'b0, 8'h00);
        access(1'b1, 8'h20, 8'h44, 1'b0, 8'h00);
        access(1'b0, 8'h10, 8'h00, 1'b1, 8'h20);

        access(1'b1, 8'h40, 8'h77, 1'b0, 8'h00);
        access(1'b1, 8'h41, 8'h55, 1'b0, 8'h00);
        access(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        reset_during(8'h40, 8'h99, 3);
        access(1'b0, 8'h40, 8'h00, 1'b0, 8'h00);
        reset_during(8'h41, 8'hAB, 5);
        access(1'b0, 8'h41, 8'h00, 1'b0, 8'h00);

        @(posedge clk);
        #1;
        read  = 1'b1;
        write = 1'b1;
        address   = 8'h2A;
        writedata = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("both_busywait", int'(busywait), 0);
        end
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clk);
        check("both_readdata", int'(readdata), int'(rd_model));
        access(1'b0, 8'h2A, 8'h00, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
